// File: rtl/security_pkg.sv
// security_pkg: shared state encodings, status codes and default command codes.
package security_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_DISARMED = 3'd0;
  localparam state_t S_EXIT     = 3'd1;
  localparam state_t S_ARMED    = 3'd2;
  localparam state_t S_ENTRY    = 3'd3;
  localparam state_t S_ALARM    = 3'd4;
  localparam state_t S_EMERG    = 3'd5;
  localparam logic [2:0] ST_RESET    = 3'b111;
  localparam logic [2:0] ST_DISARMED = 3'b001;
  localparam logic [2:0] ST_EXIT     = 3'b011;
  localparam logic [2:0] ST_ARMED    = 3'b010;
  localparam logic [2:0] ST_ENTRY    = 3'b101;
  localparam logic [2:0] ST_ALARM    = 3'b100;
  localparam logic [2:0] ST_EMERG    = 3'b110;
  localparam int CMD_DISARM_DEF = 1;
  localparam int CMD_ARM_DEF    = 11;
  localparam int CMD_PANIC_DEF  = 13;
  localparam int CMD_CLEAR_DEF  = 0;
  function automatic logic [2:0] status_of(state_t s);
    return s == S_EXIT  ? ST_EXIT  :
           s == S_ARMED ? ST_ARMED :
           s == S_ENTRY ? ST_ENTRY :
           s == S_ALARM ? ST_ALARM :
           s == S_EMERG ? ST_EMERG : ST_DISARMED;
  endfunction
  function automatic int max3(int a, int b, int c);
    return (a > b ? a : b) > c ? (a > b ? a : b) : c;
  endfunction
endpackage

// File: rtl/sec_delay_timer.sv
// sec_delay_timer: loadable down-counter that holds at zero, shared by all delays.
module sec_delay_timer #(
  parameter int W = 7
) (
  input  logic         i_Clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign zero_o = cnt_q == '0;
  assign cnt_d = clr_i ? '0 : load_i ? val_i : zero_o ? cnt_q : cnt_q - 1'b1;
  always_ff @(posedge i_Clk) begin
    cnt_q <= reset ? '0 : cnt_d;
  end
endmodule

// File: rtl/security_zone_control.sv
// security_zone_control: keypad/zone alarm FSM with exit, entry and alarm delays.
module security_zone_control
  import security_pkg::*;
#(
  parameter int N_ZONES   = 4,
  parameter int CODE_W    = 4,
  parameter int EXIT_DLY  = 16,
  parameter int ENTRY_DLY = 16,
  parameter int ALARM_TO  = 64,
  parameter int MAX_BAD   = 3,
  parameter logic [CODE_W-1:0] CMD_DISARM = CODE_W'(CMD_DISARM_DEF),
  parameter logic [CODE_W-1:0] CMD_ARM    = CODE_W'(CMD_ARM_DEF),
  parameter logic [CODE_W-1:0] CMD_PANIC  = CODE_W'(CMD_PANIC_DEF),
  parameter logic [CODE_W-1:0] CMD_CLEAR  = CODE_W'(CMD_CLEAR_DEF)
) (
  input  logic               i_Clk,
  input  logic               reset,
  input  logic               i_code_valid,
  input  logic [CODE_W-1:0]  i_code,
  input  logic [N_ZONES-1:0] i_zone,
  input  logic [N_ZONES-1:0] i_zone_mask,
  input  logic               i_panic,
  output logic [2:0]         o_state,
  output logic [2:0]         o_status,
  output logic [N_ZONES-1:0] o_zone_latched,
  output logic               o_buzzer_en,
  output logic               o_led_en
);
  localparam int TW = $clog2(max3(EXIT_DLY, ENTRY_DLY, ALARM_TO)) + 1;
  localparam int BW = $clog2(MAX_BAD + 1);
  state_t state_q, state_d;
  logic [2:0] status_q;
  logic [N_ZONES-1:0] zl_q, zl_d, trip;
  logic [BW-1:0] bad_q, bad_d, bad_inc;
  logic [TW-1:0] tmr_val;
  logic tmr_clr, tmr_ld, tmr_zero;
  logic is_dis, is_arm, is_pnc, is_clr, cmd_ok, inval, panic, watch, bad_hit;
  assign is_dis  = i_code_valid && i_code == CMD_DISARM;
  assign is_arm  = i_code_valid && i_code == CMD_ARM;
  assign is_pnc  = i_code_valid && i_code == CMD_PANIC;
  assign is_clr  = i_code_valid && i_code == CMD_CLEAR;
  assign cmd_ok  = is_dis || is_arm || is_pnc || is_clr;
  assign inval   = i_code_valid && !cmd_ok;
  assign panic   = i_panic || is_pnc;
  assign trip    = i_zone & ~i_zone_mask;
  assign watch   = state_q == S_ARMED || state_q == S_ENTRY;
  assign bad_inc = bad_q == BW'(MAX_BAD) ? bad_q : bad_q + 1'b1;
  assign bad_hit = inval && watch && bad_inc >= BW'(MAX_BAD);
  // Single priority chain; no-op commands fall through to lower-priority events.
  always_comb begin
    state_d = state_q;
    tmr_clr = 1'b0;
    tmr_ld  = 1'b0;
    tmr_val = '0;
    if (state_q > S_EMERG) begin
      state_d = S_DISARMED;
      tmr_clr = 1'b1;
    end else if (panic) begin
      state_d = S_EMERG;
      tmr_clr = 1'b1;
    end else if (is_dis && state_q != S_DISARMED) begin
      state_d = S_DISARMED;
      tmr_clr = 1'b1;
    end else if (is_arm && state_q == S_DISARMED) begin
      state_d = S_EXIT;
      tmr_ld  = 1'b1;
      tmr_val = TW'(EXIT_DLY - 1);
    end else if (state_q == S_ARMED && |trip) begin
      state_d = S_ENTRY;
      tmr_ld  = 1'b1;
      tmr_val = TW'(ENTRY_DLY - 1);
    end else if (tmr_zero && state_q == S_EXIT) begin
      state_d = S_ARMED;
    end else if (tmr_zero && state_q == S_ALARM) begin
      state_d = S_ARMED;
    end else if ((tmr_zero && state_q == S_ENTRY) || bad_hit) begin
      state_d = S_ALARM;
      tmr_ld  = 1'b1;
      tmr_val = TW'(ALARM_TO - 1);
    end
  end
  assign bad_d = (cmd_ok || state_d == S_ALARM || state_q > S_EMERG) ? '0 :
                 (inval && watch) ? bad_inc : bad_q;
  assign zl_d = (state_q == S_DISARMED && is_clr) ? '0 :
                (watch || state_q == S_ALARM) ? zl_q | trip : zl_q;
  always_ff @(posedge i_Clk) begin
    state_q  <= reset ? S_DISARMED : state_d;
    status_q <= reset ? ST_RESET : status_of(state_q);
    zl_q     <= reset ? '0 : zl_d;
    bad_q    <= reset ? '0 : bad_d;
  end
  sec_delay_timer #(.W(TW)) u_tmr (
    .i_Clk (i_Clk),
    .reset (reset),
    .clr_i (tmr_clr),
    .load_i(tmr_ld),
    .val_i (tmr_val),
    .zero_o(tmr_zero)
  );
  assign o_state        = state_q;
  assign o_status       = status_q;
  assign o_zone_latched = zl_q;
  assign o_buzzer_en    = state_q == S_ALARM || state_q == S_EMERG;
  assign o_led_en       = o_buzzer_en || state_q == S_ENTRY;
endmodule

// File: tb/tb_security_zone_control.sv
// tb_security_zone_control: directed scenarios plus random traffic against a deadline-based model.
module tb_security_zone_control;
  localparam int NZ = 4, CW = 4, EXD = 16, END = 16, ALT = 64, MB = 3;
  localparam int DIS = 0, EXT = 1, ARM = 2, ENT = 3, ALM = 4, EMG = 5;
  logic i_Clk = 0, reset = 1, i_code_valid = 0, i_panic = 0;
  logic [CW-1:0] i_code = 0;
  logic [NZ-1:0] i_zone = 0, i_zone_mask = 0;
  logic [2:0] o_state, o_status;
  logic [NZ-1:0] o_zone_latched;
  logic o_buzzer_en, o_led_en;
  int total = 0, errs = 0;
  int cyc = 0, m_st = DIS, m_stat = 7, m_bad = 0, m_end = 0;
  logic [NZ-1:0] m_zl = 0;
  int stat_tbl[6] = '{1, 3, 2, 5, 4, 6};

  security_zone_control dut (
    .i_Clk(i_Clk), .reset(reset), .i_code_valid(i_code_valid), .i_code(i_code),
    .i_zone(i_zone), .i_zone_mask(i_zone_mask), .i_panic(i_panic),
    .o_state(o_state), .o_status(o_status), .o_zone_latched(o_zone_latched),
    .o_buzzer_en(o_buzzer_en), .o_led_en(o_led_en)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Delays are tracked as the absolute edge number at which they expire.
  task automatic model_step();
    int e = cyc + 1, ns = m_st;
    bit v = i_code_valid, iscmd, inval, expired;
    int c = int'(i_code);
    logic [NZ-1:0] trip = i_zone & ~i_zone_mask;
    iscmd = v && (c == 1 || c == 11 || c == 13 || c == 0);
    inval = v && !iscmd;
    expired = e >= m_end;
    if (reset) begin
      m_st = DIS; m_stat = 7; m_zl = 0; m_bad = 0;
      return;
    end
    m_stat = stat_tbl[m_st];
    if (m_st == DIS && v && c == 0) m_zl = 0;
    else if (m_st == ARM || m_st == ENT || m_st == ALM) m_zl |= trip;
    if (i_panic || (v && c == 13)) ns = EMG;
    else if (v && c == 1 && m_st != DIS) ns = DIS;
    else if (v && c == 11 && m_st == DIS) begin ns = EXT; m_end = e + EXD; end
    else if (m_st == ARM && trip != 0) begin ns = ENT; m_end = e + END; end
    else if (m_st == EXT && expired) ns = ARM;
    else if (m_st == ENT && expired) begin ns = ALM; m_end = e + ALT; end
    else if (m_st == ALM && expired) ns = ARM;
    else if (inval && (m_st == ARM || m_st == ENT) && m_bad + 1 >= MB) begin ns = ALM; m_end = e + ALT; end
    if (iscmd) m_bad = 0;
    else if (inval && (m_st == ARM || m_st == ENT)) m_bad = (m_bad + 1 > MB) ? MB : m_bad + 1;
    if (ns == ALM) m_bad = 0;
    m_st = ns;
  endtask

  task automatic tick();
    model_step();
    @(posedge i_Clk);
    #1;
    cyc++;
    check("state", o_state, m_st);
    check("status", o_status, m_stat);
    check("zone_latched", o_zone_latched, m_zl);
    check("buzzer", o_buzzer_en, m_st == ALM || m_st == EMG);
    check("led", o_led_en, m_st == ALM || m_st == EMG || m_st == ENT);
  endtask

  task automatic send(int code);
    i_code_valid = 1;
    i_code = CW'(code);
    tick();
    i_code_valid = 0;
  endtask

  task automatic run_while(int st, int lim, output int n);
    n = 0;
    while (int'(o_state) == st && n < lim) begin tick(); n++; end
  endtask

  task automatic get_armed();
    int n;
    send(1);
    send(11);
    run_while(EXT, 40, n);
  endtask

  initial begin
    int n, buz;
    tick();
    tick();
    check("reset_status", o_status, 7);
    reset = 0;
    tick();
    check("post_reset_status", o_status, 1);
    send(11);
    tick();
    check("exit_status", o_status, 3);
    run_while(EXT, 40, n);
    check("exit_len", n, EXD - 1);
    tick();
    check("armed_status", o_status, 2);
    i_zone = 4'b0100;
    tick();
    i_zone = 0;
    check("entry_latch", o_zone_latched, 4'b0100);
    buz = 0;
    repeat (9) begin tick(); buz |= int'(o_buzzer_en); end
    send(1);
    check("entry_disarm", o_state, DIS);
    check("no_buzz", buz, 0);
    send(0);
    get_armed();
    i_zone_mask = 4'b0001;
    i_zone = 4'b0001;
    repeat (3) tick();
    check("masked_stay", o_state, ARM);
    i_zone = 4'b0010;
    tick();
    i_zone = 0;
    run_while(ENT, 40, n);
    check("entry_len", n, END);
    run_while(ALM, 100, n);
    check("alarm_len", n, ALT);
    check("alarm_to_armed", o_state, ARM);
    i_zone_mask = 0;
    send(7); tick(); send(7); tick();
    check("bad_two", o_state, ARM);
    send(7);
    check("bad_alarm", o_state, ALM);
    send(1);
    get_armed();
    send(7); send(1);
    check("bad_then_disarm", o_state, DIS);
    send(11);
    tick();
    i_panic = 1;
    tick();
    i_panic = 0;
    check("panic_emerg", o_state, EMG);
    check("panic_buzz", o_buzzer_en, 1);
    repeat (5) tick();
    reset = 1;
    tick();
    check("emerg_reset_st", o_status, 7);
    reset = 0;
    tick();
    check("emerg_reset_st2", o_status, 1);
    for (int i = 0; i < 4000; i++) begin
      reset = $urandom_range(0, 999) == 0;
      i_panic = $urandom_range(0, 399) == 0;
      i_code_valid = $urandom_range(0, 14) == 0;
      n = $urandom_range(0, 15);
      i_code = n < 2 ? 4'd1 : n < 5 ? 4'd11 : n == 5 ? 4'd13 : n == 6 ? 4'd0 : CW'($urandom);
      i_zone = $urandom_range(0, 24) == 0 ? NZ'($urandom) : '0;
      if (i % 300 == 0) i_zone_mask = NZ'($urandom);
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, errs);
    $finish;
  end
endmodule

// File: doc/security_zone_control.md
SECURITY_ZONE_CONTROL -- requirements
Module: security_zone_control

Interface
REQ-001 Parameter N_ZONES, default 4: number of sensor zones, legal range 1..16.
REQ-002 Parameter CODE_W, default 4: keypad code width.
REQ-003 Parameter EXIT_DLY, default 16: exit-delay length in cycles, minimum 1.
REQ-004 Parameter ENTRY_DLY, default 16: entry-delay length in cycles, minimum 1.
REQ-005 Parameter ALARM_TO, default 64: alarm duration in cycles, minimum 1.
REQ-006 Parameter MAX_BAD, default 3: consecutive invalid codes that force ALARM, minimum 1.
REQ-007 Parameters CMD_DISARM=1, CMD_ARM=11, CMD_PANIC=13, CMD_CLEAR=0, each CODE_W wide: command codes.
REQ-008 One clock; reset is synchronous and active-high.
REQ-009 i_Clk  in  1  main clock.
REQ-010 reset  in  1  synchronous active-high reset.
REQ-011 i_code_valid  in  1  one-cycle strobe qualifying i_code.
REQ-012 i_code  in  CODE_W  decoded keypad code.
REQ-013 i_zone  in  N_ZONES  sensor trip lines, active-high, already synchronised.
REQ-014 i_zone_mask  in  N_ZONES  bypass; a 1 ignores that zone.
REQ-015 i_panic  in  1  hardware panic button, level.
REQ-016 o_state  out  3  current state encoding.
REQ-017 o_status  out  3  registered status code for the WIFI link.
REQ-018 o_zone_latched  out  N_ZONES  zones that caused entry or alarm.
REQ-019 o_buzzer_en  out  1  buzzer enable.
REQ-020 o_led_en  out  1  LED-bar enable.

Function
REQ-021 States and o_state encodings SHALL be: DISARMED=0, EXIT_DELAY=1, ARMED=2, ENTRY_DELAY=3, ALARM=4, EMERGENCY=5; the values 6 and 7 are illegal and SHALL return to DISARMED on the next edge.
REQ-022 Commands SHALL be sampled only on an edge where i_code_valid=1; the state change is visible on o_state at that same edge.
REQ-023 Priority within one cycle SHALL be: i_panic or CMD_PANIC > CMD_DISARM > CMD_ARM > zone trip > timer expiry > invalid-code count.
REQ-024 Any state + panic -> EMERGENCY.
REQ-025 Any state except DISARMED + CMD_DISARM -> DISARMED; this clears the timer and the bad-code counter but keeps o_zone_latched.
REQ-026 DISARMED + CMD_ARM -> EXIT_DELAY with the timer loaded to EXIT_DLY-1; DISARMED + CMD_CLEAR clears o_zone_latched.
REQ-027 In EXIT_DELAY the timer SHALL decrement each cycle and the block SHALL go to ARMED on the cycle the timer is 0, so the total stay in EXIT_DELAY is exactly EXIT_DLY cycles; zone trips are ignored.
REQ-028 ARMED + any bit of (i_zone & ~i_zone_mask) -> ENTRY_DELAY with the timer loaded to ENTRY_DLY-1; tripped bits SHALL be OR-ed into o_zone_latched.
REQ-029 ENTRY_DELAY -> ALARM on timer 0; zones tripped during ENTRY_DELAY and ALARM SHALL also OR into o_zone_latched.
REQ-030 ALARM loads the timer to ALARM_TO-1 on entry and -> ARMED on timer 0; o_zone_latched is retained.
REQ-031 EMERGENCY has no timeout and is left only by CMD_DISARM.
REQ-032 An invalid code is i_code_valid=1 with i_code matching no command; a valid code clears the counter.
REQ-033 In ARMED or ENTRY_DELAY, the MAX_BAD-th consecutive invalid code -> ALARM; invalid codes in other states are ignored.
REQ-034 CMD_ARM outside DISARMED and CMD_CLEAR outside DISARMED SHALL be no-ops that count as valid codes.
REQ-035 o_buzzer_en and o_led_en SHALL be 1 exactly when state is ALARM or EMERGENCY; o_led_en SHALL also be 1 in ENTRY_DELAY.
REQ-036 o_status SHALL be registered with a one-cycle lag from o_state, using the codes DISARMED=001, EXIT=011, ARMED=010, ENTRY=101, ALARM=100, EMERGENCY=110.
REQ-037 The timer width SHALL be $clog2 of the largest delay parameter, plus 1 bit.

Reset
REQ-038 While reset=1 at an edge: state=DISARMED, o_status=111, o_zone_latched=0, timer=0, bad-code counter=0, o_buzzer_en=0, o_led_en=0; reset overrides panic.
REQ-039 Reset mid-delay or mid-alarm SHALL abandon the countdown; the first post-reset o_status SHALL be 001.

Structure
REQ-040 A shared package security_pkg SHALL hold the state typedef, the status codes and the default command codes.
REQ-041 Sub-module sec_delay_timer SHALL provide a loadable down-counter with load, value and zero flag; it is instanced once and shared by all delays.

Verification
REQ-042 Scenario arm-exit: CMD_ARM in DISARMED -> EXIT_DELAY for exactly 16 cycles, then ARMED, with o_status 011 then 010.
REQ-043 Scenario entry-disarm: ARMED, i_zone=0100 -> ENTRY_DELAY, o_zone_latched=0100; CMD_DISARM at cycle 10 -> DISARMED, buzzer never asserted.
REQ-044 Scenario masked zone: ARMED with i_zone_mask=0001 and i_zone=0001 -> stays ARMED; i_zone=0010 -> ENTRY_DELAY, then ALARM after 16 cycles, then ARMED after 64 cycles.
REQ-045 Scenario bad codes: ARMED with codes 7, 7, 7 -> ALARM on the 3rd; codes 7, 1 -> DISARMED with the counter cleared.
REQ-046 Scenario panic/reset: i_panic during EXIT_DELAY -> EMERGENCY with buzzer on; reset asserted while in EMERGENCY -> DISARMED, o_status 111 then 001.
